fft_frame_feeder: RTL and testbench
===================================

# fft_frame_feeder

Read-side consumer of the 8-to-16-bit audio CDC prefetch FIFO. It pops 16-bit PCM samples from the FIFO and packs them into fixed-length frames for the FFT core. Output is a valid/ready stream with a last-sample marker. It also keeps frame statistics and raises a sticky underrun flag for the audio FFT/FIR path.

## Interface
- DATA_WIDTH, 16, sample width; must be even.
- FRAME_LEN, 1024, samples per frame; allowed range 2..65536.
- CNT_WIDTH, 10, sample index width; equals ceil(log2(FRAME_LEN)).
- SWAP_BYTES, 0, when 1, output = {low half, high half} of the FIFO word. Used when the write side packs bytes in the opposite order.

Ports:
- clk  in  1  single clock; the FIFO read clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  frame enable; sampled only at frame boundaries.
- clr_stat  in  1  one-cycle pulse; clears frame_cnt and underrun.
- fifo_rd_vld  in  1  prefetch FIFO has a word on fifo_rd_data.
- fifo_rd_data  in  DATA_WIDTH  FIFO head word.
- fifo_rd_en  out  1  pop strobe; combinational.
- m_tdata  out  DATA_WIDTH  sample to the FFT.
- m_tvalid  out  1  m_tdata is valid.
- m_tready  in  1  FFT accepts the sample.
- m_tlast  out  1  marks sample index FRAME_LEN-1.
- frame_cnt  out  16  count of completed frames; wraps modulo 2^16.
- underrun  out  1  sticky: the FIFO ran empty mid-frame.
- busy  out  1  state==RUN or m_tvalid.

## Operation
- FIFO semantics (prefetch): fifo_rd_data is valid whenever fifo_rd_vld=1. Asserting fifo_rd_en with fifo_rd_vld=1 pops that word at the clock edge.
- There is a one-entry output register holding m_tdata, m_tvalid and m_tlast.
  - Define "can_load" = !m_tvalid || m_tready.
  - fifo_rd_en = (state==RUN) && fifo_rd_vld && can_load.
- State IDLE:
  - fifo_rd_en=0 and idx=0.
  - en=1 → RUN on the next edge.
- State RUN:
  - On each pop: load the output register with the (optionally swapped) word, set m_tvalid=1 and m_tlast=(idx==FRAME_LEN-1).
  - idx increments on each pop and wraps to 0 after FRAME_LEN-1.
  - On the pop where idx==FRAME_LEN-1: stay in RUN if en=1 (back-to-back frames, no gap), otherwise go to IDLE.
  - Once a frame has started it always completes FRAME_LEN samples. Dropping en mid-frame has no effect until the boundary.
- Output register behaviour:
  - It clears m_tvalid when m_tvalid && m_tready && !fifo_rd_en.
  - Load and accept in the same cycle is a pass-through: the register takes the new word and m_tvalid stays 1.
- frame_cnt increments on each accepted beat where m_tvalid && m_tready && m_tlast.
- underrun is set when state==RUN && idx!=0 && !fifo_rd_vld && can_load, i.e. the FFT is starved mid-frame.
  - An empty FIFO at idx==0 is not an underrun.
  - A stall caused by backpressure is not an underrun.
- clr_stat clears frame_cnt and underrun.
  - If clr_stat coincides with an underrun set condition, underrun ends at 1.
  - If clr_stat coincides with a frame_cnt increment, frame_cnt ends at 1.
- Reset (async assert, any time, including mid-frame):
  - state=IDLE, idx=0.
  - All outputs are 0: m_tdata, m_tvalid, m_tlast, frame_cnt, underrun, busy, fifo_rd_en.
  - The partial frame is discarded. The FIFO is not flushed by this block.

## Timing
- fifo_rd_en is combinational from registered state/idx/m_tvalid and the inputs fifo_rd_vld and m_tready. There is no path from fifo_rd_data.
- The first pop can occur no earlier than 1 cycle after en is first seen high in IDLE.
- Latency: a word popped at edge k appears on m_tdata with m_tvalid=1 from edge k to k+1.
- Throughput is 1 sample/cycle when fifo_rd_vld=1 and m_tready=1 continuously, including across frame boundaries when en=1.
- m_tdata, m_tvalid and m_tlast are held stable while m_tvalid && !m_tready.
- frame_cnt and underrun update 1 edge after the qualifying event.

## Test plan
- Basic framing:
  - Stimulus: FRAME_LEN=8, en=1, m_tready=1, FIFO preloaded with 0x0001..0x0010.
  - Required: 16 contiguous beats; m_tlast only on 0x0008 and 0x0010; frame_cnt=2; underrun=0; first beat 2 cycles after en rises.
- Backpressure:
  - Stimulus: m_tready driven with a random 50% pattern over 3 frames.
  - Required: output sequence equals input sequence with no drop or duplicate; fifo_rd_en never asserted while m_tvalid && !m_tready; data held stable while stalled.
- Underrun:
  - Stimulus: FIFO supplies 5 samples, then refills after 10 cycles.
  - Required: underrun=1 after sample 5; m_tlast still on the 8th sample; frame_cnt=1.
  - Then pulse clr_stat. Required: frame_cnt=0 and underrun=0.
- en drop:
  - Stimulus: en deasserted at idx=3 with 20 words queued.
  - Required: exactly 8 beats; state returns to IDLE; fifo_rd_en=0 afterwards; 12 words remain queued; busy=0 after the last accept.
- Byte swap:
  - Stimulus: SWAP_BYTES=1, FIFO word 0x1234.
  - Required: m_tdata=0x3412.
- Reset mid-frame:
  - Stimulus: rst_n low at idx=4.
  - Required: all outputs 0 immediately. After release with en=1, the next m_tlast occurs on the 8th subsequent beat.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: pops PCM words from the prefetch FIFO and streams them to the
// FFT core as fixed-length frames, keeping a completed-frame count and a sticky underrun flag.
module fft_frame_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_WIDTH  = 10,
  parameter int SWAP_BYTES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr_stat,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [15:0]           frame_cnt,
  output logic                  underrun,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [CNT_WIDTH-1:0]  idx;
  logic                  can_load;
  logic                  at_last;
  logic                  frame_done;
  logic                  underrun_set;
  logic [DATA_WIDTH-1:0] word;

  assign can_load     = !m_tvalid || m_tready;
  assign fifo_rd_en   = (state == ST_RUN) && fifo_rd_vld && can_load;
  assign at_last      = (idx == LAST_IDX);
  assign frame_done   = m_tvalid && m_tready && m_tlast;
  assign underrun_set = (state == ST_RUN) && (idx != '0) && !fifo_rd_vld && can_load;
  assign busy         = (state == ST_RUN) || m_tvalid;

  // Byte order of the write side is fixed at build time, so the swap is pure wiring.
  generate
    if (SWAP_BYTES != 0) begin : g_swap
      assign word = {fifo_rd_data[DATA_WIDTH/2-1:0], fifo_rd_data[DATA_WIDTH-1:DATA_WIDTH/2]};
    end else begin : g_noswap
      assign word = fifo_rd_data;
    end
  endgenerate

  // Frame sequencer: en only matters in IDLE and on the last pop of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (fifo_rd_en) begin
            idx <= at_last ? '0 : idx + 1'b1;
            if (at_last && !en) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (fifo_rd_en) begin
      m_tdata  <= word;
      m_tvalid <= 1'b1;
      m_tlast  <= at_last;
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

  // A clear coinciding with a qualifying event keeps that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      if (clr_stat) frame_cnt <= frame_done ? 16'd1 : 16'd0;
      else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      underrun <= underrun_set || (underrun && !clr_stat);
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder with FRAME_LEN=8: a queue-based FIFO, a frame/scoreboard
// reference model, a vector table for basic framing and directed corner-case sequences.
module tb_fft_frame_feeder;

  localparam int DW   = 16;
  localparam int FLEN = 8;

  logic          clk = 1'b0;
  logic          rst_n, en, clr_stat, fifo_rd_vld, m_tready;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en, m_tvalid, m_tlast, underrun, busy;
  logic [DW-1:0] m_tdata;
  logic [15:0]   frame_cnt;
  logic          sw_rd_en, sw_tvalid, sw_tlast, sw_underrun, sw_busy;
  logic [DW-1:0] sw_tdata;
  logic [15:0]   sw_frame_cnt;

  always #5 clk = ~clk;

  fft_frame_feeder #(.DATA_WIDTH(DW), .FRAME_LEN(FLEN), .CNT_WIDTH(3), .SWAP_BYTES(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_stat(clr_stat),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .frame_cnt(frame_cnt), .underrun(underrun), .busy(busy)
  );

  fft_frame_feeder #(.DATA_WIDTH(DW), .FRAME_LEN(FLEN), .CNT_WIDTH(3), .SWAP_BYTES(1)) dut_swap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_stat(clr_stat),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(sw_rd_en),
    .m_tdata(sw_tdata), .m_tvalid(sw_tvalid), .m_tready(m_tready), .m_tlast(sw_tlast),
    .frame_cnt(sw_frame_cnt), .underrun(sw_underrun), .busy(sw_busy)
  );

  typedef struct { logic [15:0] data; logic last; } beat_t;
  typedef struct { logic [15:0] word; logic expLast; logic [15:0] expFrames; } vec_t;

  beat_t       sb[$];
  logic [15:0] fifoQ[$];
  vec_t        basicTbl[16];
  bit          supplyOn, inRun, expUnder, swapSeen;
  int          pos, expFrames, popCount, accCount, lastAt;
  int          nChecks, nFails;
  int          cyc, startAcc, popBase, startF;

  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic refreshFifo();
    fifo_rd_vld  = supplyOn && (fifoQ.size() > 0);
    fifo_rd_data = (fifoQ.size() > 0) ? fifoQ[0] : 16'hDEAD;
  endtask

  task automatic modelReset();
    sb.delete();
    inRun = 0; pos = 0; expFrames = 0; expUnder = 0;
  endtask

  // One clock cycle: compare against the model before the edge, advance the model, compare stats after.
  task automatic applyStimulus();
    bit expValid, canLoad, expRd, acc, undSet, clrNow, enNow, frameInc;
    logic [15:0] word;
    beat_t b;
    refreshFifo();
    #1;
    expValid = sb.size() > 0;
    canLoad  = !expValid || m_tready;
    expRd    = inRun && fifo_rd_vld && canLoad;
    acc      = expValid && m_tready;
    undSet   = inRun && (pos != 0) && !fifo_rd_vld && canLoad;
    clrNow   = clr_stat;
    enNow    = en;
    word     = fifo_rd_data;
    frameInc = 0;
    checkOutput("m_tvalid", m_tvalid, expValid);
    checkOutput("fifo_rd_en", fifo_rd_en, expRd);
    checkOutput("busy", busy, inRun || expValid);
    checkOutput("swap_tvalid", sw_tvalid, expValid);
    checkOutput("swap_rd_en", sw_rd_en, expRd);
    if (expValid && !m_tready) checkOutput("rd_en_while_stalled", fifo_rd_en, 0);
    if (expValid) begin
      checkOutput("m_tdata", m_tdata, sb[0].data);
      checkOutput("m_tlast", m_tlast, sb[0].last);
      checkOutput("swap_tdata", sw_tdata, swap16(sb[0].data));
      checkOutput("swap_tlast", sw_tlast, sb[0].last);
    end
    @(posedge clk);
    @(negedge clk);
    if (acc) begin
      accCount++;
      if (sb[0].last) begin
        frameInc = 1;
        lastAt = accCount;
      end
      void'(sb.pop_front());
    end
    expFrames = clrNow ? int'(frameInc) : (expFrames + int'(frameInc)) % 65536;
    expUnder  = undSet || (expUnder && !clrNow);
    if (expRd) begin
      b.data = word;
      b.last = (pos == FLEN - 1);
      sb.push_back(b);
      void'(fifoQ.pop_front());
      popCount++;
      if (pos == FLEN - 1) begin
        pos = 0;
        if (!enNow) inRun = 0;
      end else begin
        pos++;
      end
    end else if (!inRun && enNow) begin
      inRun = 1;
    end
    checkOutput("frame_cnt", frame_cnt, expFrames);
    checkOutput("underrun", underrun, expUnder);
    checkOutput("swap_frame_cnt", sw_frame_cnt, expFrames);
    checkOutput("swap_underrun", sw_underrun, expUnder);
    checkOutput("swap_busy", sw_busy, inRun || (sb.size() > 0));
    refreshFifo();
    #1;
  endtask

  task automatic runToIdle(input int limit, input string name);
    cyc = 0;
    while ((inRun || sb.size() != 0) && cyc < limit) begin
      if (sb.size() > 0 && sb[0].data == 16'h1234) begin
        checkOutput("swap_word", sw_tdata, 16'h3412);
        swapSeen = 1;
      end
      applyStimulus();
      cyc++;
    end
    checkOutput(name, cyc < limit, 1);
  endtask

  initial begin
    nChecks = 0; nFails = 0; popCount = 0; accCount = 0; lastAt = 0; swapSeen = 0;
    for (int i = 0; i < 16; i++) begin
      basicTbl[i].word      = 16'(i + 1);
      basicTbl[i].expLast   = (i % 8 == 7);
      basicTbl[i].expFrames = 16'(i / 8);
    end
    rst_n = 0; en = 0; clr_stat = 0; m_tready = 0; supplyOn = 0;
    modelReset();
    refreshFifo();

    @(negedge clk);
    checkOutput("rst_tdata", m_tdata, 0);
    checkOutput("rst_tvalid", m_tvalid, 0);
    checkOutput("rst_tlast", m_tlast, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    rst_n = 1;

    $display("[TB] basic framing");
    for (int i = 0; i < 16; i++) fifoQ.push_back(basicTbl[i].word);
    supplyOn = 1; m_tready = 1; en = 1;
    applyStimulus();
    checkOutput("first_beat_early", m_tvalid, 0);
    applyStimulus();
    checkOutput("first_beat_latency", m_tvalid, 1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("basic_data", m_tdata, basicTbl[i].word);
      checkOutput("basic_last", m_tlast, basicTbl[i].expLast);
      checkOutput("basic_frames", frame_cnt, basicTbl[i].expFrames);
      checkOutput("basic_valid", m_tvalid, 1);
      if (i == 14) en = 0;
      applyStimulus();
    end
    checkOutput("basic_frame_total", frame_cnt, 2);
    checkOutput("basic_underrun", underrun, 0);
    checkOutput("basic_idle", busy, 0);

    $display("[TB] backpressure");
    startAcc = accCount; popBase = popCount; startF = expFrames;
    for (int i = 0; i < 24; i++) fifoQ.push_back(16'($urandom));
    cyc = 0;
    do begin
      m_tready = ($urandom_range(0, 1) == 1);
      en = ((popCount - popBase) < 17);
      applyStimulus();
      cyc++;
    end while ((inRun || sb.size() != 0) && cyc < 300);
    checkOutput("bp_timeout", cyc < 300, 1);
    checkOutput("bp_beats", accCount - startAcc, 24);
    checkOutput("bp_frames", frame_cnt, startF + 3);
    checkOutput("bp_fifo_empty", fifoQ.size(), 0);

    $display("[TB] underrun");
    m_tready = 1; en = 0;
    clr_stat = 1; applyStimulus(); clr_stat = 0;
    checkOutput("pre_clr_frames", frame_cnt, 0);
    startAcc = accCount;
    for (int i = 0; i < 5; i++) fifoQ.push_back(16'h0100 + 16'(i));
    en = 1;
    applyStimulus();
    en = 0;
    for (int c = 0; c < 10; c++) applyStimulus();
    checkOutput("ur_flag_set", underrun, 1);
    checkOutput("ur_no_frame_yet", frame_cnt, 0);
    for (int i = 0; i < 3; i++) fifoQ.push_back(16'h0200 + 16'(i));
    runToIdle(50, "ur_timeout");
    checkOutput("ur_last_on_8th", lastAt - startAcc, 8);
    checkOutput("ur_frames", frame_cnt, 1);
    checkOutput("ur_sticky", underrun, 1);
    clr_stat = 1; applyStimulus(); clr_stat = 0;
    checkOutput("clr_frames", frame_cnt, 0);
    checkOutput("clr_underrun", underrun, 0);

    $display("[TB] en drop");
    startAcc = accCount; popBase = popCount;
    for (int i = 0; i < 20; i++) fifoQ.push_back(16'($urandom));
    en = 1; cyc = 0;
    while ((popCount - popBase) < 3 && cyc < 20) begin
      applyStimulus();
      cyc++;
    end
    en = 0;
    runToIdle(60, "endrop_timeout");
    checkOutput("endrop_beats", accCount - startAcc, 8);
    checkOutput("endrop_queued", fifoQ.size(), 12);
    checkOutput("endrop_busy", busy, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("endrop_rd_en", fifo_rd_en, 0);
    fifoQ.delete();

    $display("[TB] byte swap");
    fifoQ.push_back(16'h1234);
    for (int i = 0; i < 7; i++) fifoQ.push_back(16'($urandom));
    en = 1;
    applyStimulus();
    en = 0;
    runToIdle(40, "swap_timeout");
    checkOutput("swap_seen", swapSeen, 1);

    $display("[TB] reset mid-frame");
    popBase = popCount;
    for (int i = 0; i < 20; i++) fifoQ.push_back(16'($urandom));
    en = 1; cyc = 0;
    while ((popCount - popBase) < 4 && cyc < 20) begin
      applyStimulus();
      cyc++;
    end
    rst_n = 0;
    #1;
    checkOutput("mid_rst_tdata", m_tdata, 0);
    checkOutput("mid_rst_tvalid", m_tvalid, 0);
    checkOutput("mid_rst_tlast", m_tlast, 0);
    checkOutput("mid_rst_frame_cnt", frame_cnt, 0);
    checkOutput("mid_rst_underrun", underrun, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_rd_en", fifo_rd_en, 0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    startAcc = accCount; lastAt = 0;
    applyStimulus();
    en = 0;
    runToIdle(40, "rst_timeout");
    checkOutput("rst_last_on_8th", lastAt - startAcc, 8);
    checkOutput("rst_queued", fifoQ.size(), 8);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      m_tready = ($urandom_range(0, 3) != 0);
      supplyOn = ($urandom_range(0, 4) != 0);
      en       = ($urandom_range(0, 9) != 0);
      clr_stat = ($urandom_range(0, 49) == 0);
      if (fifoQ.size() < 6) fifoQ.push_back(16'($urandom));
      applyStimulus();
    end
    clr_stat = 0; en = 0; m_tready = 1; supplyOn = 1;
    for (int i = 0; i < 16; i++) fifoQ.push_back(16'($urandom));
    runToIdle(100, "rand_drain_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
